// File: rtl/rr_arbiter_8.sv
// rr_arbiter_8: eight-input round-robin arbiter with locked grants and a hold timeout.
// Only one requester can be granted at a time. The grant stays until `ack` or the hold timer releases it.
// After each release, priority rotates to the index just past the requester that was served.
//
// Ports:
//   clk        - single clock, rising edge
//   rst_n      - asynchronous active-low reset
//   req[7:0]   - request lines, bit i = requester i
//   ack        - downstream consumed the current grant (only looked at while granted)
//   gnt[7:0]   - registered grant, one-hot or all-zero
//   gnt_valid  - registered, high exactly when gnt != 0
//   timeout    - registered one-cycle pulse: the previous grant was released by the hold timer
module rr_arbiter_8 #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       ack,
    output logic [7:0] gnt,
    output logic       gnt_valid,
    output logic       timeout
);

    localparam int unsigned N_REQ   = 8;
    localparam int unsigned IDX_W   = 3;
    localparam int unsigned HCNT_W  = ($clog2(TIMEOUT + 1) < 1) ? 1 : $clog2(TIMEOUT + 1);
    // Last hold cycle before a forced release. This value is meaningless when TIMEOUT == 0 and is never used then.
    localparam logic [HCNT_W-1:0] HCNT_LAST = HCNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [HCNT_W-1:0]   hcnt_q, hcnt_d;
    logic [N_REQ-1:0]    gnt_q, gnt_d;
    logic                gnt_valid_q, gnt_valid_d;
    logic                timeout_q, timeout_d;

    logic                sel_found;
    logic [IDX_W-1:0]    sel_idx;
    logic [IDX_W-1:0]    cand;

    // Find the first requester, scanning upward from ptr and wrapping modulo 8.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            cand = ptr_q + IDX_W'(i);
            if (!sel_found && req[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    // Next-state logic and registered outputs.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        idx_d       = idx_q;
        hcnt_d      = hcnt_q;
        gnt_d       = gnt_q;
        gnt_valid_d = gnt_valid_q;
        timeout_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (sel_found) begin
                    state_d     = GRANT;
                    idx_d       = sel_idx;
                    gnt_d       = N_REQ'(1) << sel_idx;
                    gnt_valid_d = 1'b1;
                    hcnt_d      = '0;
                end
            end
            GRANT: begin
                // ack takes priority over a timeout that falls in the same cycle.
                if (ack || (TIMEOUT != 0 && hcnt_q == HCNT_LAST)) begin
                    state_d     = IDLE;
                    gnt_d       = '0;
                    gnt_valid_d = 1'b0;
                    ptr_d       = idx_q + IDX_W'(1);
                    timeout_d   = !ack;
                end else begin
                    hcnt_d = hcnt_q + HCNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            idx_q       <= '0;
            hcnt_q      <= '0;
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            idx_q       <= idx_d;
            hcnt_q      <= hcnt_d;
            gnt_q       <= gnt_d;
            gnt_valid_q <= gnt_valid_d;
            timeout_q   <= timeout_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_valid = gnt_valid_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Testbench for rr_arbiter_8 (TIMEOUT=4). It runs directed scenarios and then random traffic.
// Every scenario is compared against a behavioural model of the arbitration rules.
module tb_rr_arbiter_8;

    localparam int unsigned TO = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;
    logic       ack;
    logic [7:0] gnt;
    logic       gnt_valid;
    logic       timeout;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state.
    int m_ptr;
    bit m_busy;
    int m_idx;
    int m_held;
    bit m_to;

    rr_arbiter_8 #(.TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .ack       (ack),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    function automatic int oh_idx(input logic [7:0] v);
        for (int i = 0; i < 8; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic logic [7:0] m_gnt();
        return m_busy ? 8'(32'(1) << m_idx) : 8'h00;
    endfunction

    task automatic model_reset();
        m_ptr  = 0;
        m_busy = 0;
        m_idx  = 0;
        m_held = 0;
        m_to   = 0;
    endtask

    // One clock edge of the model: m_held counts the cycles the grant has been visible so far.
    task automatic model_edge(input logic [7:0] r, input logic a);
        m_to = 0;
        if (!m_busy) begin
            if (r != 8'h00) begin
                for (int k = 0; k < 8; k++) begin
                    int j;
                    j = (m_ptr + k) % 8;
                    if (r[j]) begin
                        m_idx  = j;
                        m_busy = 1;
                        m_held = 1;
                        break;
                    end
                end
            end
        end else if (a) begin
            m_busy = 0;
            m_ptr  = (m_idx + 1) % 8;
        end else if (TO != 0 && m_held == int'(TO)) begin
            m_busy = 0;
            m_ptr  = (m_idx + 1) % 8;
            m_to   = 1;
        end else begin
            m_held++;
        end
    endtask

    task automatic cmp_all(input string tag);
        chk({tag, "_gnt"},   32'(gnt),       32'(m_gnt()));
        chk({tag, "_valid"}, 32'(gnt_valid), 32'(m_busy));
        chk({tag, "_to"},    32'(timeout),   32'(m_to));
    endtask

    // Advance one edge, update the model, then sample the outputs 1 time unit after the edge.
    task automatic step(input string tag);
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_edge(req, ack);
        #1;
        cmp_all(tag);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) step("rst");
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 8'hFF;
        ack   = 1'b0;
        model_reset();

        // Reset holds the outputs low even with every requester asserted.
        repeat (3) step("reset_hold");
        chk("reset_gnt", 32'(gnt), 32'h00);
        rst_n = 1'b1;
        step("reset_rel");
        chk("reset_first_gnt", 32'(gnt), 32'h01);

        // Rotation through all eight requesters, ending with a wrap back to 0.
        do_reset();
        req = 8'hFF;
        ack = 1'b1;
        for (int s = 1; s <= 17; s++) begin
            step("rot");
            if (s % 2 == 1) chk("rot_enc", 32'(oh_idx(gnt)), 32'(((s - 1) / 2) % 8));
            else            chk("rot_idle", 32'(gnt), 32'h00);
        end

        // Pointer skip: after index 2 is served, the wrap-around scan finds index 0 first.
        do_reset();
        req = 8'h04; ack = 1'b0;
        step("skip_a");
        chk("skip_g2", 32'(gnt), 32'h04);
        ack = 1'b1;
        step("skip_b");
        req = 8'h05; ack = 1'b0;
        step("skip_c");
        chk("skip_g0", 32'(gnt), 32'h01);
        ack = 1'b1;
        step("skip_d");
        req = 8'h05; ack = 1'b0;
        step("skip_e");
        chk("skip_g4", 32'(gnt), 32'h04);

        // Lock and timeout: hold for 4 cycles, then one idle cycle with the timeout pulse.
        do_reset();
        req = 8'h10; ack = 1'b0;
        step("lk1");
        chk("lock_c1", 32'(gnt), 32'h10);
        step("lk2");
        req = 8'h00;
        step("lk3");
        chk("lock_deassert", 32'(gnt), 32'h10);
        step("lk4");
        chk("lock_c4", 32'(gnt), 32'h10);
        req = 8'h10;
        step("lk5");
        chk("to_gnt0", 32'(gnt), 32'h00);
        chk("to_pulse", 32'(timeout), 32'h1);
        step("lk6");
        chk("regrant", 32'(gnt), 32'h10);
        chk("to_low", 32'(timeout), 32'h0);

        // ack arriving in the 4th grant cycle wins over the timeout.
        step("col2");
        step("col3");
        step("col4");
        ack = 1'b1;
        step("col5");
        chk("col_gnt", 32'(gnt), 32'h00);
        chk("col_to", 32'(timeout), 32'h0);

        // Asynchronous reset during a grant clears it without waiting for a clock edge.
        do_reset();
        req = 8'h08; ack = 1'b0;
        step("ar1");
        chk("ar_gnt8", 32'(gnt), 32'h08);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("ar_async_gnt", 32'(gnt), 32'h00);
        chk("ar_async_valid", 32'(gnt_valid), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        req = 8'h88;
        step("ar2");
        chk("ar_ptr0", 32'(gnt), 32'h08);

        // Random traffic checked against the model.
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            case ($urandom_range(0, 3))
                0:       req = 8'h00;
                1:       req = 8'(32'(1) << $urandom_range(0, 7));
                2:       req = 8'($urandom);
                default: req = 8'hFF;
            endcase
            ack = ($urandom_range(0, 9) < 2);
            step("rnd");
            chk("rnd_onehot", 32'($countones(gnt) <= 1), 32'h1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_arbiter_8.md
# rr_arbiter_8

Eight-input round-robin arbiter with locked grants and a hold timeout. It sits directly upstream of `encoder_8_3`. Its registered one-hot `gnt` vector drives the encoder's 8-bit input, which always receives a legal one-hot code or all-zero. A grant is held until the downstream consumer acknowledges it or the hold timer expires. Priority then rotates past the served requester.

## Interface
- `TIMEOUT`, default 15: maximum cycles a grant may be held without `ack`. A value of 0 disables the timeout.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `req`  in  8  request lines; bit i = requester i.
- `ack`  in  1  downstream has consumed the current grant; sampled only while `gnt_valid`=1.
- `gnt`  out  8  registered grant; always one-hot or 8'h00.
- `gnt_valid`  out  1  high exactly when `gnt` != 0.
- `timeout`  out  1  one-cycle pulse; the previous grant was released by timer, not by `ack`.

## Operation
- Internal state: FSM {IDLE, GRANT}, 3-bit priority pointer `ptr`, hold counter `hcnt` of width $clog2(TIMEOUT+1) (minimum 1).
- IDLE:
  - If `req` != 0, select the first set bit scanning `ptr`, `ptr`+1, … `ptr`+7 (mod 8).
  - Next edge: `gnt` = that bit, `gnt_valid`=1, `hcnt`=0, go to GRANT.
  - If `req`=0, stay in IDLE. `ack` is ignored in IDLE.
- GRANT:
  - `gnt` is locked. Changes on `req`, including deasserting the granted bit, do not alter it.
  - `ack`=1: next edge `gnt`=0, `gnt_valid`=0, `ptr`=granted index+1 (mod 8, 7 wraps to 0), go to IDLE.
  - `ack`=0 and TIMEOUT!=0 and `hcnt`==TIMEOUT-1: next edge release exactly as for `ack`, and additionally `timeout`=1 for one cycle.
  - Otherwise `hcnt` increments and the FSM stays in GRANT.
  - If `ack` and the timeout condition occur in the same cycle, `ack` wins and `timeout` stays 0.
- There is always one IDLE cycle between consecutive grants, so the maximum rate is one grant per 2 cycles.
- Invariant: popcount(`gnt`) ≤ 1. `gnt_valid` == |`gnt`.

## Timing
- Reset values, applied immediately when `rst_n` falls, independent of `clk`:
  - `gnt`=8'h00, `gnt_valid`=0, `timeout`=0.
  - `ptr`=0, `hcnt`=0, FSM=IDLE.
- Reset mid-grant drops the grant in the same cycle. After release, arbitration restarts from `ptr`=0.
- Request-to-grant latency: `req` sampled on edge k gives `gnt` valid after edge k (1 cycle).
- Grant duration:
  - With `ack` in the first grant cycle: exactly 1 cycle.
  - Otherwise: until the cycle carrying `ack`.
  - Bounded by TIMEOUT cycles when TIMEOUT!=0.
- `timeout` is high in the same cycle `gnt` first reads 8'h00 after a timed-out grant. It is low in all other cycles.
- All outputs are registered. There are no combinational paths from `req`/`ack` to outputs.

## Test plan
- **Reset:** hold `rst_n`=0 with `req`=8'hFF for 3 edges → `gnt`=8'h00, `gnt_valid`=0. Release `rst_n` → after next edge `gnt`=8'h01.
- **Rotation:** `req`=8'hFF, `ack`=1 constantly → `gnt` sequence 01,00,02,00,04,00,08,00,10,00,20,00,40,00,80,00,01 (wrap). Feed `gnt` to `encoder_8_3` and check that its `out` steps 0..7.
- **Pointer wrap / skip:** serve index 2 (`ptr` becomes 3), then `req`=8'h05 → `gnt`=8'h01. After its `ack`, `req`=8'h05 → `gnt`=8'h04.
- **Lock + timeout (TIMEOUT=4):** `req`=8'h10, `ack`=0 → `gnt`=8'h10 for exactly 4 cycles. Then one cycle of `gnt`=8'h00 with `timeout`=1. Then `gnt`=8'h10 again (sole requester). Deassert `req[4]` during the grant → `gnt` is unchanged.
- **Ack/timeout collision (TIMEOUT=4):** `ack`=1 in the 4th grant cycle → release with `timeout`=0.
- **Async reset mid-grant:** while `gnt`=8'h08, pull `rst_n` low between edges → `gnt`=8'h00 immediately. After release, `req`=8'h88 → `gnt`=8'h08 (`ptr` restarted at 0).
